// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_INC  = 4;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Memory request/response, redirect and decode handshake bundle for pc_fetch_unit.
interface pc_fetch_unit_if #(
  parameter int unsigned ADDR_W = 64
);
  import fetch_pkg::*;

  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [ADDR_W-1:0]  imem_req_addr;
  logic               imem_resp_valid;
  logic [INSTR_W-1:0] imem_resp_data;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_target;
  logic               id_valid;
  logic               id_ready;
  logic [ADDR_W-1:0]  id_pc;
  logic [INSTR_W-1:0] id_instr;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_target, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_target, id_ready
  );

endinterface

// File: rtl/fetch_buf.sv
// Small synchronous FIFO with flush and occupancy count; head is read from registered storage.
module fetch_buf #(
  parameter  int unsigned DEPTH = 2,
  parameter  int unsigned WIDTH = 96,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC owner and instruction fetch front end: issues in-order fetches, drops wrong-path responses
// after a redirect, and buffers instructions for decode. Option: FETCH_MISALIGN_TRAP_EN.
module pc_fetch_unit #(
  parameter int unsigned       ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int unsigned       BUF_DEPTH = 2
) (
  input logic            CLK,
  input logic            Reset,
  pc_fetch_unit_if.master bus
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic           fetch_misalign
`endif
);
  import fetch_pkg::*;

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] tag_head;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  drop;
  logic [CNT_W-1:0]  occupancy;
  logic [CNT_W-1:0]  tag_count;
  logic [CNT_W:0]    slots_used;
  logic              in_fetch;
  logic              req_fire;
  logic              resp_ack;
  logic              resp_keep;
  logic              id_fire;
  entry_t            buf_head;
  entry_t            buf_push;

`ifdef FETCH_MISALIGN_TRAP_EN
  fetch_state_t state;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state          <= FETCH;
      fetch_misalign <= 1'b0;
    end else if (bus.redirect_valid) begin
      if (bus.redirect_target[1:0] != 2'b00) begin
        state          <= HALT;
        fetch_misalign <= 1'b1;
      end else begin
        state          <= FETCH;
        fetch_misalign <= 1'b0;
      end
    end
  end

  assign in_fetch = (state == FETCH);
  assign target   = bus.redirect_target;
`else
  assign in_fetch = 1'b1;
  assign target   = {bus.redirect_target[ADDR_W-1:2], 2'b00};
`endif

  // Requests in flight plus buffered entries never exceed the buffer depth, so every
  // response always has a slot waiting for it.
  assign slots_used         = {1'b0, outstanding} + {1'b0, occupancy};
  assign bus.imem_req_valid = !Reset && in_fetch && !bus.redirect_valid &&
                              (slots_used < (CNT_W + 1)'(BUF_DEPTH));
  assign bus.imem_req_addr  = pc;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  assign resp_ack  = bus.imem_resp_valid && (tag_count != '0);
  assign resp_keep = resp_ack && (drop == '0) && !bus.redirect_valid;

  assign bus.id_valid = !Reset && (occupancy != '0);
  assign bus.id_pc    = buf_head.pc;
  assign bus.id_instr = buf_head.instr;
  assign id_fire      = bus.id_valid && bus.id_ready;

  assign buf_push.pc    = tag_head;
  assign buf_push.instr = bus.imem_resp_data;

  // Tags are never flushed: dropped responses still retire their own tag in order.
  fetch_buf #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (ADDR_W)
  ) u_tag_q (
    .clk       (CLK),
    .rst       (Reset),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (pc),
    .pop       (resp_ack),
    .head      (tag_head),
    .count     (tag_count)
  );

  fetch_buf #(
    .DEPTH (BUF_DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_instr_buf (
    .clk       (CLK),
    .rst       (Reset),
    .flush     (bus.redirect_valid),
    .push      (resp_keep),
    .push_data (buf_push),
    .pop       (id_fire),
    .head      (buf_head),
    .count     (occupancy)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(resp_ack);
      if (bus.redirect_valid) begin
        pc   <= target;
        drop <= outstanding - CNT_W'(resp_ack);
      end else begin
        if (req_fire) pc <= pc + ADDR_W'(PC_INC);
        if (resp_ack && (drop != '0)) drop <= drop - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: epoch-tagged memory model, expected stream queue.
module tb_pc_fetch_unit;
  import fetch_pkg::*;

  localparam logic [63:0] RST_PC = 64'h100;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] epc;
    int unsigned due;
    int unsigned epoch;
  } mreq_t;

  logic CLK = 1'b0;
  logic Reset;
  always #5 CLK = ~CLK;

  pc_fetch_unit_if #(.ADDR_W(64)) bus ();
`ifdef FETCH_MISALIGN_TRAP_EN
  logic fetch_misalign;
`endif

  pc_fetch_unit #(
    .ADDR_W    (64),
    .RESET_PC  (RST_PC),
    .BUF_DEPTH (2)
  ) dut (
    .CLK    (CLK),
    .Reset  (Reset),
    .bus    (bus)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_misalign (fetch_misalign)
`endif
  );

  int unsigned  checks = 0;
  int unsigned  errors = 0;
  mreq_t        memq[$];
  fetch_entry_t sb[$];
  mreq_t        cur;
  logic         cur_v = 1'b0;
  logic         halted = 1'b0;
  logic [63:0]  exp_pc = RST_PC;
  int unsigned  cyc = 0, epoch = 0, lat = 1, last_due = 0, req_count = 0;
  logic         id_fired;
  logic [63:0]  last_id_pc;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_1234;
  endfunction

  task automatic observe();
    logic         exp_rq;
    logic [63:0]  t;
    int unsigned  d;
    fetch_entry_t e;
    id_fired = 1'b0;
    if (Reset) begin
      check_eq("rst_req_valid", bus.imem_req_valid, 0);
      check_eq("rst_id_valid", bus.id_valid, 0);
      return;
    end
    exp_rq = !bus.redirect_valid && !halted &&
             (memq.size() + (cur_v ? 1 : 0) + sb.size() < 2);
    check_eq("req_valid", bus.imem_req_valid, exp_rq);
    check_eq("id_valid", bus.id_valid, sb.size() != 0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check_eq("misalign", fetch_misalign, halted);
`endif
    if (bus.id_valid && bus.id_ready) begin
      id_fired   = 1'b1;
      last_id_pc = bus.id_pc;
      if (sb.size() == 0) check_eq("id_spurious", bus.id_valid, 0);
      else begin
        e = sb.pop_front();
        check_eq("id_pc", bus.id_pc, e.pc);
        check_eq("id_instr", bus.id_instr, e.instr);
      end
    end
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      check_eq("req_addr", bus.imem_req_addr, exp_pc);
      d = cyc + lat;
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      memq.push_back('{addr: bus.imem_req_addr, epc: exp_pc, due: d, epoch: epoch});
      exp_pc = exp_pc + 64'd4;
      req_count++;
    end
    if (cur_v && !bus.redirect_valid && cur.epoch == epoch)
      sb.push_back('{pc: cur.epc, instr: data_of(cur.addr)});
    if (bus.redirect_valid) begin
      t = bus.redirect_target;
      sb.delete();
      epoch++;
`ifdef FETCH_MISALIGN_TRAP_EN
      halted = (t[1:0] != 2'b00);
      exp_pc = t;
`else
      exp_pc = t & ~64'h3;
`endif
    end
  endtask

  task automatic advance();
    cur_v = 1'b0;
    if (Reset) begin
      memq.delete();
      sb.delete();
      exp_pc = RST_PC;
      halted = 1'b0;
    end else if (memq.size() != 0 && memq[0].due <= cyc) begin
      cur   = memq.pop_front();
      cur_v = 1'b1;
    end
    bus.imem_resp_valid = cur_v;
    bus.imem_resp_data  = cur_v ? data_of(cur.addr) : 32'h0;
    bus.redirect_valid  = 1'b0;
  endtask

  task automatic step();
    @(negedge CLK);
    observe();
    @(posedge CLK);
    cyc++;
    #1;
    advance();
  endtask

  task automatic redirect(input logic [63:0] t);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = t;
    step();
  endtask

  task automatic wait_id(input string tag, input logic [63:0] exp);
    for (int i = 0; i < 40; i++) begin
      step();
      if (id_fired) break;
    end
    check_eq({tag, "_seen"}, id_fired, 1);
    check_eq(tag, last_id_pc, exp);
  endtask

  initial begin
    int unsigned rc;
    Reset               = 1'b1;
    bus.imem_req_ready  = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    bus.id_ready        = 1'b0;
    repeat (2) step();
    Reset = 1'b0;

    // Decode stalled: exactly two fetches, then PC holds at 0x108.
    rc = req_count;
    repeat (6) step();
    check_eq("hold_req_count", 64'(req_count - rc), 2);
    check_eq("hold_addr", bus.imem_req_addr, 64'h108);
    bus.id_ready = 1'b1;
    wait_id("stream0", 64'h100);
    wait_id("stream1", 64'h104);
    wait_id("stream2", 64'h108);

    // Two requests in flight, then redirect: both late responses are dropped.
    lat = 3;
    for (int i = 0; i < 40 && (memq.size() + (cur_v ? 1 : 0)) != 2; i++) step();
    check_eq("two_outstanding", memq.size() + (cur_v ? 1 : 0), 2);
    redirect(64'h400);
    wait_id("redir_first", 64'h400);
    wait_id("redir_second", 64'h404);

    // Redirect coinciding with a response and a dequeue.
    lat = 1;
    for (int i = 0; i < 40 && !(bus.imem_resp_valid && bus.id_valid); i++) step();
    check_eq("collide_found", bus.imem_resp_valid && bus.id_valid, 1);
    redirect(64'h800);
    #1;
    check_eq("redir_issue_valid", bus.imem_req_valid, 1);
    check_eq("redir_issue_addr", bus.imem_req_addr, 64'h800);
    wait_id("collide_first", 64'h800);

    // PC wrap at the top of the address space.
    redirect(64'hFFFF_FFFF_FFFF_FFFC);
    rc = req_count;
    for (int i = 0; i < 20 && req_count == rc; i++) step();
    check_eq("wrap_addr", bus.imem_req_addr, 64'h0);
    wait_id("wrap_id0", 64'hFFFF_FFFF_FFFF_FFFC);
    wait_id("wrap_id1", 64'h0);

    // Misaligned redirect target.
    redirect(64'h402);
`ifdef FETCH_MISALIGN_TRAP_EN
    rc = req_count;
    repeat (5) step();
    check_eq("halt_no_req", 64'(req_count - rc), 0);
    check_eq("halt_flag", fetch_misalign, 1);
    redirect(64'h500);
    wait_id("resume", 64'h500);
`else
    wait_id("align_clear", 64'h400);
`endif

    // Reset with requests still in flight.
    lat = 3;
    for (int i = 0; i < 20 && memq.size() == 0; i++) step();
    Reset = 1'b1;
    repeat (2) step();
    Reset = 1'b0;
    lat = 1;
    wait_id("after_reset", RST_PC);

    // Random traffic: stalls, variable latency, backpressure, redirects.
    for (int i = 0; i < 600; i++) begin
      bus.id_ready       = ($urandom_range(0, 3) != 0);
      bus.imem_req_ready = ($urandom_range(0, 4) != 0);
      lat                = $urandom_range(1, 4);
      if ($urandom_range(0, 19) == 0) begin
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = {48'h0, 16'($urandom_range(0, 16'hFFFF))};
      end
      step();
    end
    bus.id_ready       = 1'b1;
    bus.imem_req_ready = 1'b1;
    redirect(64'h1000);
    wait_id("final", 64'h1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
